// File: rtl/ifu_pc_ctrl.sv
// ifu_pc_ctrl: instruction-fetch PC sequencer.
// It issues one instruction-memory request at a time and holds the returned word for decode.
// It handles branch redirects and drops any response that was in flight when a redirect arrived.
// PC increment is computed by an external 16-bit prefix adder.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   stall                        back-end stall (blocks requests, holds instr)
//   br_valid, br_target          one-cycle redirect pulse and target
//   adder_a/b/kin, adder_sum     external adder operands (combinational) and result
//   imem_req/addr/gnt            fetch request handshake
//   imem_rvalid/rdata            fetch response
//   instr_valid/instr/instr_pc   fetched instruction to decode
//   dec_ready                    decode accepts instr
//   pc_ovf                       sticky PC overflow flag (only with IFU_OVF_TRAP_EN)
//
// Optional feature: define IFU_OVF_TRAP_EN to trap on PC carry-out instead of wrapping.
module ifu_pc_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [15:0] br_target,
  output logic [15:0] adder_a,
  output logic [15:0] adder_b,
  output logic [1:0]  adder_kin,
  input  logic [16:0] adder_sum,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
`ifdef IFU_OVF_TRAP_EN
  output logic        pc_ovf,
`endif
  input  logic        dec_ready
);

  localparam int unsigned AW = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          imem_req_d;
  logic [AW-1:0] imem_addr_d;
  logic          instr_valid_d;
  logic [AW-1:0] instr_d, instr_pc_d;

  // External adder: current PC plus constant increment, carry-in killed.
  assign adder_a   = pc_q;
  assign adder_b   = PC_INC;
  assign adder_kin = 2'b00;

`ifdef IFU_OVF_TRAP_EN
  assign pc_ovf = ovf_q;
`else
  logic unused_carry;
  assign unused_carry = adder_sum[16];
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    ovf_d         = ovf_q;
    instr_valid_d = instr_valid;
    instr_d       = instr;
    instr_pc_d    = instr_pc;

    case (state_q)
      IDLE: begin
        // A set overflow flag parks the fetcher here until a redirect.
        if (br_valid) begin
          pc_d    = br_target;
          state_d = REQ;
        end else if (!ovf_q) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (imem_req && imem_gnt) begin
          state_d = WAIT;
          // The granted request is now stale; its response must be dropped.
          if (br_valid) drop_d = 1'b1;
        end
        if (br_valid) pc_d = br_target;
      end

      WAIT: begin
        if (br_valid) begin
          pc_d = br_target;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            pc_d          = adder_sum[AW-1:0];
            instr_valid_d = 1'b1;
            state_d       = HOLD;
`ifdef IFU_OVF_TRAP_EN
            if (adder_sum[16]) ovf_d = 1'b1;
`endif
          end
        end
      end

      HOLD: begin
        if (br_valid) begin
          pc_d    = br_target;
          state_d = REQ;
        end else if (dec_ready && !stall) begin
          instr_valid_d = 1'b0;
          state_d       = ovf_q ? IDLE : REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect overrides everything: kill the held instruction and clear the trap.
    if (br_valid) begin
      instr_valid_d = 1'b0;
      ovf_d         = 1'b0;
    end

    imem_req_d  = (state_d == REQ) && !stall;
    imem_addr_d = pc_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      imem_req    <= imem_req_d;
      imem_addr   <= imem_addr_d;
      instr_valid <= instr_valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Self-checking bench for ifu_pc_ctrl: directed vector table, corner-case sequences,
// and a randomized run against a transaction-level fetch model.
module tb_ifu_pc_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_valid, imem_gnt, imem_rvalid, dec_ready;
  logic [15:0] br_target, imem_rdata;
  logic [15:0] adder_a, adder_b, imem_addr, instr, instr_pc;
  logic [1:0]  adder_kin;
  logic [16:0] adder_sum;
  logic        imem_req, instr_valid;
`ifdef IFU_OVF_TRAP_EN
  logic        pc_ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external adder (carry-in killed).
  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};

  ifu_pc_ctrl #(.RESET_PC(RST_PC), .PC_INC(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .adder_a(adder_a), .adder_b(adder_b), .adder_kin(adder_kin), .adder_sum(adder_sum),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
`ifdef IFU_OVF_TRAP_EN
    .pc_ovf(pc_ovf),
`endif
    .dec_ready(dec_ready)
  );

  typedef struct packed {
    logic        st, br;
    logic [15:0] tgt;
    logic        g, rv;
    logic [15:0] rd;
    logic        dr;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr, e_ipc;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic st, input logic br, input logic [15:0] tgt,
                              input logic g, input logic rv, input logic [15:0] rd,
                              input logic dr, input logic e_req, input logic [15:0] e_addr,
                              input logic e_valid, input logic [15:0] e_instr,
                              input logic [15:0] e_ipc);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.g = g; v.rv = rv; v.rd = rd; v.dr = dr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_valid = 1'b0; br_target = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic st);
    rst_n = 1'b0;
    idle_inputs();
    stall = st;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Randomized-run model state
  logic [15:0] next_addr, pend_addr, resp_addr, exp_instr, exp_pc, tgt_mask;
  logic        outstanding, pend_live, exp_valid, delivered;
  int          resp_wait, grants;

  initial begin
    // Directed table: fetch sequence, decode back-pressure, redirect corner cases.
    tbl[0]  = mk(0,0,16'h0,    0,0,16'h0,    0, 1,16'h0000, 0,16'h0000,16'h0000);
    tbl[1]  = mk(0,0,16'h0,    1,0,16'h0,    0, 0,16'h0000, 0,16'h0000,16'h0000);
    tbl[2]  = mk(0,0,16'h0,    0,1,16'h1111, 0, 0,16'h0000, 1,16'h1111,16'h0000);
    tbl[3]  = mk(0,0,16'h0,    0,0,16'h0,    1, 1,16'h0002, 0,16'h1111,16'h0000);
    tbl[4]  = mk(0,0,16'h0,    1,0,16'h0,    0, 0,16'h0000, 0,16'h1111,16'h0000);
    tbl[5]  = mk(0,0,16'h0,    0,1,16'h2222, 0, 0,16'h0000, 1,16'h2222,16'h0002);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(0,0,16'h0,   0,0,16'h0,    0, 0,16'h0000, 1,16'h2222,16'h0002);
    tbl[11] = mk(0,0,16'h0,    0,0,16'h0,    1, 1,16'h0004, 0,16'h2222,16'h0002);
    tbl[12] = mk(0,0,16'h0,    1,0,16'h0,    0, 0,16'h0000, 0,16'h2222,16'h0002);
    tbl[13] = mk(0,1,16'h1234, 0,0,16'h0,    0, 0,16'h0000, 0,16'h2222,16'h0002);
    tbl[14] = mk(0,0,16'h0,    0,1,16'hBEEF, 0, 1,16'h1234, 0,16'h2222,16'h0002);
    tbl[15] = mk(0,0,16'h0,    1,0,16'h0,    0, 0,16'h0000, 0,16'h2222,16'h0002);
    tbl[16] = mk(0,0,16'h0,    0,1,16'h3333, 0, 0,16'h0000, 1,16'h3333,16'h1234);
    tbl[17] = mk(1,0,16'h0,    0,0,16'h0,    1, 0,16'h0000, 1,16'h3333,16'h1234);
    tbl[18] = mk(0,0,16'h0,    0,0,16'h0,    1, 1,16'h1236, 0,16'h3333,16'h1234);
    tbl[19] = mk(0,1,16'h0100, 1,0,16'h0,    0, 0,16'h0000, 0,16'h3333,16'h1234);
    tbl[20] = mk(0,0,16'h0,    0,1,16'h5555, 0, 1,16'h0100, 0,16'h3333,16'h1234);
    tbl[21] = mk(0,0,16'h0,    1,0,16'h0,    0, 0,16'h0000, 0,16'h3333,16'h1234);
    tbl[22] = mk(0,1,16'h0200, 0,1,16'h6666, 0, 1,16'h0200, 0,16'h3333,16'h1234);
    tbl[23] = mk(0,0,16'h0,    0,0,16'h0,    0, 1,16'h0200, 0,16'h3333,16'h1234);
    tbl[24] = mk(0,0,16'h0,    0,1,16'h7777, 0, 1,16'h0200, 0,16'h3333,16'h1234);

    // Reset values
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   16'(imem_req), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_ipc",   instr_pc, 16'h0000);
    chk("adder_b",   adder_b, 16'h0002);
    chk("adder_kin", 16'(adder_kin), 16'h0);
`ifdef IFU_OVF_TRAP_EN
    chk("rst_ovf",   16'(pc_ovf), 16'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      stall = tbl[i].st; br_valid = tbl[i].br; br_target = tbl[i].tgt;
      imem_gnt = tbl[i].g; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
      dec_ready = tbl[i].dr;
      step();
      chk($sformatf("row%0d_req", i), 16'(imem_req), 16'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), 16'(instr_valid), 16'(tbl[i].e_valid));
      chk($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("row%0d_ipc", i), instr_pc, tbl[i].e_ipc);
    end

    // Stall through REQ with a redirect in the middle
    do_reset(1'b1);
    step();
    chk("stall_req0", 16'(imem_req), 16'h0);
    br_valid = 1'b1; br_target = 16'h4000;
    step();
    br_valid = 1'b0;
    chk("stall_req1", 16'(imem_req), 16'h0);
    chk("stall_adder_a", adder_a, 16'h4000);
    step();
    chk("stall_req2", 16'(imem_req), 16'h0);
    stall = 1'b0;
    step();
    chk("stall_rel_req", 16'(imem_req), 16'h1);
    chk("stall_rel_addr", imem_addr, 16'h4000);

    // PC wrap / overflow trap
    br_valid = 1'b1; br_target = 16'hFFFE;
    step();
    br_valid = 1'b0;
    chk("wrap_addr", imem_addr, 16'hFFFE);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 16'hABCD;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_instr", instr, 16'hABCD);
    chk("wrap_ipc", instr_pc, 16'hFFFE);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
`ifdef IFU_OVF_TRAP_EN
    chk("ovf_set", 16'(pc_ovf), 16'h1);
    repeat (3) begin
      step();
      chk("ovf_parked_req", 16'(imem_req), 16'h0);
    end
    br_valid = 1'b1; br_target = 16'h0010;
    step();
    br_valid = 1'b0;
    chk("ovf_clear", 16'(pc_ovf), 16'h0);
    chk("ovf_redir_req", 16'(imem_req), 16'h1);
    chk("ovf_redir_addr", imem_addr, 16'h0010);
`else
    chk("wrap_next_req", 16'(imem_req), 16'h1);
    chk("wrap_next_addr", imem_addr, 16'h0000);
`endif

    // Asynchronous reset while waiting for a response
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req", 16'(imem_req), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 16'(instr_valid), 16'h0);
    chk("async_instr", instr, 16'h0000);
    chk("async_ipc", instr_pc, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 16'h9999;
    step();
    imem_rvalid = 1'b0;
    chk("post_rst_req", 16'(imem_req), 16'h1);
    chk("post_rst_addr", imem_addr, RST_PC);
    chk("post_rst_instr", instr, 16'h0000);
    chk("post_rst_valid", 16'(instr_valid), 16'h0);

    // Randomized run against the transaction-level model
    do_reset(1'b0);
`ifdef IFU_OVF_TRAP_EN
    tgt_mask = 16'h7FFE;
`else
    tgt_mask = 16'hFFFE;
`endif
    next_addr = RST_PC; pend_addr = '0; resp_addr = '0; exp_instr = '0; exp_pc = '0;
    outstanding = 1'b0; pend_live = 1'b0; exp_valid = 1'b0; resp_wait = 0; grants = 0;
    for (int c = 0; c < 3000; c++) begin
      if (outstanding) chk("one_outstanding", 16'(imem_req), 16'h0);
      stall     = ($urandom_range(0, 3) == 0);
      dec_ready = ($urandom_range(0, 2) != 0);
      br_valid  = ($urandom_range(0, 15) == 0);
      br_target = 16'($urandom) & tgt_mask;
      imem_gnt  = imem_req && !outstanding && ($urandom_range(0, 1) == 1);
      if (outstanding && resp_wait == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem(resp_addr);
      end else if (!outstanding && $urandom_range(0, 19) == 0) begin
        imem_rvalid = 1'b1; imem_rdata = 16'($urandom);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = '0;
      end

      delivered = 1'b0;
      if (imem_gnt) begin
        chk("grant_addr", imem_addr, next_addr);
        outstanding = 1'b1;
        resp_addr   = next_addr;
        pend_addr   = next_addr;
        pend_live   = 1'b1;
        resp_wait   = $urandom_range(0, 2);
        next_addr   = next_addr + 16'd2;
        grants++;
      end else if (outstanding) begin
        if (resp_wait == 0) begin
          outstanding = 1'b0;
          if (pend_live && !br_valid) delivered = 1'b1;
        end else begin
          resp_wait--;
        end
      end

      if (br_valid) begin
        exp_valid = 1'b0;
        next_addr = br_target;
        pend_live = 1'b0;
      end else if (delivered) begin
        exp_valid = 1'b1;
        exp_instr = mem(pend_addr);
        exp_pc    = pend_addr;
      end else if (exp_valid && dec_ready && !stall) begin
        exp_valid = 1'b0;
      end

      step();
      chk("rand_valid", 16'(instr_valid), 16'(exp_valid));
      if (exp_valid) begin
        chk("rand_instr", instr, exp_instr);
        chk("rand_ipc", instr_pc, exp_pc);
      end
    end
    idle_inputs();
    chk("rand_progress", 16'(grants > 200), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
